// File: rtl/uart_pkg.sv
// Shared UART definitions for the transmit and receive paths.
//   tx_state_t    : transmitter FSM states
//   UART_DATA_W   : payload bits per frame
//   UART_IDLE_LVL : line level while no frame is in flight
package uart_pkg;

  localparam int   UART_DATA_W   = 8;
  localparam logic UART_IDLE_LVL = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with a first-word-fall-through head.
// Ports:
//   clk, reset   : clock and synchronous active-high reset (contents discarded)
//   push, wdata  : write request and data (ignored when full)
//   pop          : read request, advances past the current head (ignored when empty)
//   head         : oldest stored word, valid whenever empty is low
//   full, empty  : occupancy flags
//   count        : number of stored words, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [DATA_W-1:0]        wdata,
  input  logic                     pop,
  output logic [DATA_W-1:0]        head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              push_ok;
  logic              pop_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_buffered_tx.sv
// Buffered UART transmitter: bytes enter a FIFO over a valid/ready handshake
// and are serialised LSB-first, 8N1 by default.
// Optional feature macro: UART_TX_PARITY_EN -> 8E1 frames (even parity bit
// inserted between data bit 7 and the stop bit).
// Ports:
//   clk          : clock, rising edge
//   i_reset      : synchronous active-high reset, truncates any frame
//   i_data       : byte to send
//   i_valid      : i_data valid; accepted when o_ready is also high
//   o_ready      : FIFO has room
//   o_uart_tx    : registered serial line, idle high
//   o_busy       : frame in flight or bytes still buffered
//   o_fifo_count : bytes currently buffered
//
// state  | meaning
// IDLE   | line idle, waiting for a buffered byte
// START  | start bit (low)
// DATA   | data bits 0..7, shift[0] on the line
// PARITY | even parity bit (only with UART_TX_PARITY_EN)
// STOP   | stop bit (high); pops the next byte directly if one is waiting
module uart_buffered_tx import uart_pkg::*; #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          i_reset,
  input  logic [UART_DATA_W-1:0]        i_data,
  input  logic                          i_valid,
  output logic                          o_ready,
  output logic                          o_uart_tx,
  output logic                          o_busy,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count
);

  localparam int TW = $clog2(CLKS_PER_BIT);

  tx_state_t              state;
  tx_state_t              state_next;
  logic [TW-1:0]          timer;
  logic                   timer_done;
  logic [2:0]             bit_idx;
  logic [UART_DATA_W-1:0] shift;
  logic [UART_DATA_W-1:0] shift_next;
  logic [UART_DATA_W-1:0] head;
  logic                   tx_next;
  logic                   push;
  logic                   pop;
  logic                   fifo_full;
  logic                   fifo_empty;
`ifdef UART_TX_PARITY_EN
  logic                   parity;
`endif

  assign push       = i_valid && o_ready;
  assign o_ready    = !fifo_full;
  assign timer_done = (timer == TW'(CLKS_PER_BIT - 1));
  assign o_busy     = (state != IDLE) || !fifo_empty;

  sync_fifo #(
    .DATA_W (UART_DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (i_reset),
    .push  (push),
    .wdata (i_data),
    .pop   (pop),
    .head  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (o_fifo_count)
  );

  always_ff @(posedge clk) begin
    if (i_reset) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          state_next = START;
          pop        = 1'b1;
        end
      end
      START: if (timer_done) state_next = DATA;
      DATA: begin
        if (timer_done && bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
          state_next = PARITY;
`else
          state_next = STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (timer_done) state_next = STOP;
`endif
      STOP: begin
        if (timer_done) begin
          // Chain straight into the next frame so there is no idle gap.
          if (!fifo_empty) begin
            state_next = START;
            pop        = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // The line level is computed from the upcoming state so that the
  // registered output changes on the same edge as the state.
  always_comb begin
    shift_next = shift;
    if (pop)                            shift_next = head;
    else if (state == DATA && timer_done) shift_next = {1'b0, shift[UART_DATA_W-1:1]};

    tx_next = UART_IDLE_LVL;
    case (state_next)
      START:   tx_next = ~UART_IDLE_LVL;
      DATA:    tx_next = shift_next[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_next = parity;
`endif
      default: tx_next = UART_IDLE_LVL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      timer     <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      o_uart_tx <= UART_IDLE_LVL;
`ifdef UART_TX_PARITY_EN
      parity    <= 1'b0;
`endif
    end else begin
      shift     <= shift_next;
      o_uart_tx <= tx_next;
      if (state == IDLE || timer_done) timer <= '0;
      else                             timer <= timer + 1'b1;
      if (state != DATA)               bit_idx <= '0;
      else if (timer_done)             bit_idx <= bit_idx + 1'b1;
`ifdef UART_TX_PARITY_EN
      if (pop) parity <= ^head;
`endif
    end
  end

endmodule

// File: tb/tb_uart_buffered_tx.sv
module tb_uart_buffered_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  logic       clk = 1'b0;
  logic       i_reset;
  logic [7:0] i_data;
  logic       i_valid;
  logic       o_ready;
  logic       o_uart_tx;
  logic       o_busy;
  logic [2:0] o_fifo_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] data;
    logic       par;
  } vec_t;

  vec_t vecs [9];

  uart_buffered_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk          (clk),
    .i_reset      (i_reset),
    .i_data       (i_data),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .o_uart_tx    (o_uart_tx),
    .o_busy       (o_busy),
    .o_fifo_count (o_fifo_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic exp_bit(input vec_t v, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return v.data[k-1];
    if (k == NBITS - 1) return 1'b1;
    return v.par;
  endfunction

  task automatic push_byte(input logic [7:0] b);
    @(negedge clk);
    i_data  = b;
    i_valid = 1'b1;
    @(posedge clk);
    #1 i_valid = 1'b0;
  endtask

  task automatic wait_start(input int budget, input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (o_uart_tx !== 1'b0 && n < budget);
    chk(name, {31'd0, o_uart_tx}, 32'd0);
  endtask

  // Called at the negedge of the first start-bit cycle; ends at the negedge
  // of the last stop-bit cycle. Every cycle of every bit is sampled.
  task automatic check_frame(input vec_t v, input string name);
    logic ok;
    logic bok = 1'b1;
    for (int k = 0; k < NBITS; k++) begin
      ok = 1'b1;
      for (int c = 0; c < CPB; c++) begin
        if (k != 0 || c != 0) @(negedge clk);
        if (o_uart_tx !== exp_bit(v, k)) ok = 1'b0;
        if (o_busy !== 1'b1) bok = 1'b0;
      end
      chk($sformatf("%s %02h bit%0d", name, v.data, k), {31'd0, ok}, 32'd1);
    end
    chk($sformatf("%s %02h busy", name, v.data), {31'd0, bok}, 32'd1);
  endtask

  initial begin
    vecs[0] = '{8'hA5, 1'b0};
    vecs[1] = '{8'h01, 1'b1};
    vecs[2] = '{8'h02, 1'b1};
    vecs[3] = '{8'h03, 1'b0};
    vecs[4] = '{8'hFF, 1'b0};
    vecs[5] = '{8'h00, 1'b0};
    vecs[6] = '{8'h07, 1'b1};
    vecs[7] = '{8'h80, 1'b1};
    vecs[8] = '{8'h5A, 1'b0};

    i_reset = 1'b1;
    i_valid = 1'b0;
    i_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1 i_reset = 1'b0;
    @(negedge clk);
    chk("reset tx",    {31'd0, o_uart_tx}, 32'd1);
    chk("reset busy",  {31'd0, o_busy},    32'd0);
    chk("reset count", {29'd0, o_fifo_count}, 32'd0);
    chk("reset ready", {31'd0, o_ready},   32'd1);

    // Single frames, one per table entry, with exact start latency.
    for (int i = 0; i < 9; i++) begin
      push_byte(vecs[i].data);
      @(negedge clk);
      chk($sformatf("single %02h count1", vecs[i].data), {29'd0, o_fifo_count}, 32'd1);
      chk($sformatf("single %02h line still idle", vecs[i].data), {31'd0, o_uart_tx}, 32'd1);
      wait_start(1, $sformatf("single %02h start latency", vecs[i].data));
      check_frame(vecs[i], "single");
      @(negedge clk);
      chk($sformatf("single %02h busy after", vecs[i].data), {31'd0, o_busy}, 32'd0);
      chk($sformatf("single %02h line after", vecs[i].data), {31'd0, o_uart_tx}, 32'd1);
      repeat (2) @(negedge clk);
    end

    // Back-to-back frames with no gap.
    fork
      begin
        push_byte(8'h01);
        push_byte(8'h02);
        push_byte(8'h03);
      end
      begin
        wait_start(4, "b2b start");
        check_frame(vecs[1], "b2b");
        @(negedge clk);
        check_frame(vecs[2], "b2b");
        @(negedge clk);
        check_frame(vecs[3], "b2b");
        @(negedge clk);
        chk("b2b busy after", {31'd0, o_busy}, 32'd0);
      end
    join
    repeat (2) @(negedge clk);

    // Producer holds i_valid for six bytes; FIFO fills.
    fork
      begin
        int idx   = 0;
        int guard = 0;
        bit seen  = 1'b0;
        while (idx < 6 && guard < 400) begin
          @(negedge clk);
          guard++;
          i_data  = vecs[idx].data;
          i_valid = 1'b1;
          if (idx == 5 && !seen) begin
            seen = 1'b1;
            chk("hold ready at full", {31'd0, o_ready}, 32'd0);
            chk("hold count at full", {29'd0, o_fifo_count}, 32'd4);
          end
          if (o_ready) begin
            @(posedge clk);
            #1 idx++;
          end
        end
        i_valid = 1'b0;
        chk("hold all accepted", idx, 32'd6);
      end
      begin
        wait_start(8, "hold start");
        check_frame(vecs[0], "hold");
        for (int i = 1; i < 6; i++) begin
          @(negedge clk);
          check_frame(vecs[i], "hold");
        end
        @(negedge clk);
        chk("hold busy after", {31'd0, o_busy}, 32'd0);
      end
    join
    repeat (2) @(negedge clk);

    // Reset in the middle of data bit 3 with a second byte buffered.
    push_byte(8'hFF);
    push_byte(8'hFF);
    repeat (17) @(negedge clk);
    chk("rst mid line bit3", {31'd0, o_uart_tx}, 32'd1);
    chk("rst mid count",     {29'd0, o_fifo_count}, 32'd1);
    chk("rst mid busy",      {31'd0, o_busy}, 32'd1);
    i_reset = 1'b1;
    @(posedge clk);
    #1 i_reset = 1'b0;
    @(negedge clk);
    chk("rst line",  {31'd0, o_uart_tx}, 32'd1);
    chk("rst count", {29'd0, o_fifo_count}, 32'd0);
    chk("rst busy",  {31'd0, o_busy}, 32'd0);
    chk("rst ready", {31'd0, o_ready}, 32'd1);
    begin
      logic quiet = 1'b1;
      repeat (60) begin
        @(negedge clk);
        if (o_uart_tx !== 1'b1 || o_busy !== 1'b0) quiet = 1'b0;
      end
      chk("rst stays quiet", {31'd0, quiet}, 32'd1);
    end

    // Push coinciding with the pop at the end of a stop bit, count=2.
    fork
      begin
        push_byte(vecs[6].data);
        push_byte(vecs[7].data);
        push_byte(vecs[8].data);
      end
      begin
        wait_start(4, "swap start");
        check_frame(vecs[6], "swap");
        chk("swap count before", {29'd0, o_fifo_count}, 32'd2);
        i_data  = vecs[5].data;
        i_valid = 1'b1;
        @(posedge clk);
        #1 i_valid = 1'b0;
        @(negedge clk);
        chk("swap count kept", {29'd0, o_fifo_count}, 32'd2);
        chk("swap no gap", {31'd0, o_uart_tx}, 32'd0);
        check_frame(vecs[7], "swap");
        @(negedge clk);
        check_frame(vecs[8], "swap");
        @(negedge clk);
        check_frame(vecs[5], "swap");
        @(negedge clk);
        chk("swap busy after", {31'd0, o_busy}, 32'd0);
      end
    join

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
